// File: rtl/page_output_drain_pkg.sv
// Shared definitions for the page output path: drain FSM encoding and beat/line geometry.
package page_output_drain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DONE  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   localparam int BEAT_W     = 512;
   localparam int BEAT_BYTES = BEAT_W / 8;
   localparam int LINE_BYTES = 128;
   localparam int BYTES_W    = 7;

endpackage

// File: rtl/page_output_drain_if.sv
// Output beat stream of the page drain.
interface page_output_drain_if;
   import page_output_drain_pkg::*;

   // A beat transfers on a cycle where dout_valid & dout_ready; once raised, dout_valid
   // stays high and data/last/bytes stay stable until that transfer happens.
   logic [BEAT_W-1:0]  dout_data;
   logic               dout_valid;
   logic               dout_ready;
   logic               dout_last;
   logic [BYTES_W-1:0] dout_bytes;

   modport master (output dout_data, output dout_valid, output dout_last,
                   output dout_bytes, input dout_ready);
   modport slave  (input dout_data, input dout_valid, input dout_last,
                   input dout_bytes, output dout_ready);

endinterface

// File: rtl/page_output_drain_line_fifo.sv
// Synchronous line buffer with occupancy count; head word is read combinationally.
module line_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 1024,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_data,
   input  logic             i_pop,
   output logic [W-1:0]     o_data,
   output logic [CNT_W-1:0] o_count
);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (i_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (i_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/page_output_drain.sv
// Drains a finished page from the history BRAM banks as 512-bit beats, then pulses cl_finish.
module page_output_drain
   import page_output_drain_pkg::*;
#(
   parameter int NUM_BANK   = 16,
   parameter int BANK_AW    = 9,
   parameter int PAGE_LEN_W = 17,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_page_finish,
   input  logic [PAGE_LEN_W-1:0]   i_page_len,
   output logic                    o_rd_en,
   output logic [BANK_AW-1:0]      o_rd_addr,
   input  logic [NUM_BANK*64-1:0]  i_rd_data,
   page_output_drain_if.master     dout,
   output logic                    o_cl_finish,
   output logic                    o_busy,
   output state_t                  o_state
);

   localparam int LINE_W  = NUM_BANK * 64;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int LINES_W = PAGE_LEN_W - 6;
   localparam int BEATS_W = PAGE_LEN_W - 5;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

   state_t              r_state;
   logic                r_pf_q;
   logic [LINES_W-1:0]  r_lines;
   logic [BEATS_W-1:0]  r_beats;
   logic [BYTES_W-1:0]  r_tail;
   logic [BANK_AW-1:0]  r_rd_addr;
   logic [LINES_W-1:0]  r_rd_cnt;
   logic [RD_LAT-1:0]   r_tag;
   logic [CNT_W-1:0]    r_inflight;
   logic [BEATS_W-1:0]  r_beat_cnt;
   logic                r_half;
   logic                r_cl_finish;
   logic                r_busy;

   logic                w_start;
   logic [LINES_W-1:0]  w_lines;
   logic [BEATS_W-1:0]  w_beats;
   logic [BYTES_W-1:0]  w_tail;
   logic [CNT_W-1:0]    w_count;
   logic [CNT_W:0]      w_occ;
   logic                w_rd_en;
   logic                w_push;
   logic                w_valid;
   logic                w_last;
   logic                w_accept;
   logic                w_pop;
   logic [LINE_W-1:0]   w_head;

   assign w_start = i_page_finish & ~r_pf_q;
   assign w_lines = LINES_W'(i_page_len[PAGE_LEN_W-1:7]) + LINES_W'(|i_page_len[6:0]);
   assign w_beats = BEATS_W'(i_page_len[PAGE_LEN_W-1:6]) + BEATS_W'(|i_page_len[5:0]);
   assign w_tail  = (i_page_len[5:0] == 6'd0) ? BYTES_W'(BEAT_BYTES) : {1'b0, i_page_len[5:0]};

   // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
   assign w_occ   = {1'b0, w_count} + {1'b0, r_inflight};
   assign w_rd_en = (r_state == ST_READ) && (w_occ < DEPTH_L);
   assign w_push  = r_tag[RD_LAT-1];

   assign w_valid  = (w_count != '0);
   assign w_last   = w_valid && (r_beat_cnt == r_beats - 1'b1);
   assign w_accept = w_valid && dout.dout_ready;
   assign w_pop    = w_accept && (r_half || w_last);

   line_fifo #(.DEPTH(FIFO_DEPTH), .W(LINE_W)) u_line_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (i_rd_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pf_q      <= 1'b0;
         r_lines     <= '0;
         r_beats     <= '0;
         r_tail      <= '0;
         r_rd_addr   <= '0;
         r_rd_cnt    <= '0;
         r_tag       <= '0;
         r_inflight  <= '0;
         r_beat_cnt  <= '0;
         r_half      <= 1'b0;
         r_cl_finish <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_pf_q     <= i_page_finish;
         r_tag      <= (r_tag << 1) | RD_LAT'(w_rd_en);
         r_inflight <= r_inflight + CNT_W'(w_rd_en) - CNT_W'(w_push);
         if (w_rd_en) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_rd_cnt  <= r_rd_cnt + 1'b1;
         end
         if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_half     <= w_pop ? 1'b0 : ~r_half;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_busy     <= 1'b1;
                  r_lines    <= w_lines;
                  r_beats    <= w_beats;
                  r_tail     <= w_tail;
                  r_rd_addr  <= '0;
                  r_rd_cnt   <= '0;
                  r_beat_cnt <= '0;
                  r_half     <= 1'b0;
                  r_state    <= (i_page_len == '0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: begin
               if (w_rd_en && (r_rd_cnt == r_lines - 1'b1))
                  r_state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (w_accept && w_last)
                  r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_cl_finish <= 1'b1;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // A level left high here must not start another drain.
               r_cl_finish <= 1'b0;
               r_busy      <= 1'b0;
               if (!i_page_finish)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_rd_en     = w_rd_en;
   assign o_rd_addr   = r_rd_addr;
   assign o_cl_finish = r_cl_finish;
   assign o_busy      = r_busy;
   assign o_state     = r_state;

   assign dout.dout_valid = w_valid;
   assign dout.dout_last  = w_last;
   assign dout.dout_bytes = !w_valid ? '0 : (w_last ? r_tail : BYTES_W'(BEAT_BYTES));
   assign dout.dout_data  = !w_valid ? '0 :
                            (r_half ? w_head[2*BEAT_W-1:BEAT_W] : w_head[BEAT_W-1:0]);

endmodule

// File: tb/tb_page_output_drain.sv
// Directed and randomized page drains against a BRAM model and a beat-level reference.
module tb_page_output_drain;
   import page_output_drain_pkg::*;

   localparam int NUM_BANK   = 16;
   localparam int BANK_AW    = 9;
   localparam int PAGE_LEN_W = 17;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int LINE_W     = NUM_BANK * 64;
   localparam int W          = 1 + 7 + BEAT_W;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   page_finish = 1'b0;
   logic [PAGE_LEN_W-1:0]  page_len = '0;
   logic                   rd_en;
   logic [BANK_AW-1:0]     rd_addr;
   logic [LINE_W-1:0]      rd_data;
   logic                   cl_finish;
   logic                   busy;
   state_t                 state;

   page_output_drain_if dif ();

   page_output_drain #(
      .NUM_BANK(NUM_BANK), .BANK_AW(BANK_AW), .PAGE_LEN_W(PAGE_LEN_W),
      .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_page_finish(page_finish), .i_page_len(page_len),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .dout(dif),
      .o_cl_finish(cl_finish), .o_busy(busy), .o_state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // BRAM model: page content plus an RD_LAT-deep read pipeline.
   logic [LINE_W-1:0] mem  [1 << BANK_AW];
   logic [LINE_W-1:0] pipe [RD_LAT];

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   always @(posedge clk) begin
      pipe[0] <= rd_en ? mem[rd_addr] : rand_line();
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign rd_data = pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
         $error("check %s", tag);
      end
   endtask

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return (c % 2) == 0;
         2:       return 1'($urandom_range(0, 1));
         3:       return c >= 50;
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_en"},   rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_valid"},   dif.dout_valid, 0);
      check({tag, "_data"},    dif.dout_data, 0);
      check({tag, "_last"},    dif.dout_last, 0);
      check({tag, "_bytes"},   dif.dout_bytes, 0);
      check({tag, "_cl"},      cl_finish, 0);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_state"},   state, ST_IDLE);
   endtask

   // One full drain; cycle 0 is the cycle in which page_finish rises.
   task automatic run_page(input int len, input int mode, input bit hold);
      int beats, lines, tail;
      int next_addr, n_rd, first_valid, cl_cnt, cl_cyc, last_acc, stall_rd;
      bit stalled, done;
      logic [W-1:0] held, e, obs;
      beats = (len + 63) / 64;
      lines = (len + 127) / 128;
      tail  = (len % 64 == 0) ? 64 : len % 64;
      next_addr = 0; n_rd = 0; first_valid = -1; cl_cnt = 0; cl_cyc = -1;
      last_acc = -1; stall_rd = 0; stalled = 0; done = 0; held = '0;
      exp_q.delete();
      for (int k = 0; k < beats; k++) begin
         logic [LINE_W-1:0] ln;
         logic [BEAT_W-1:0] bd;
         logic              lst;
         logic [6:0]        by;
         ln  = mem[k / 2];
         bd  = (k % 2 == 1) ? ln[LINE_W-1:BEAT_W] : ln[BEAT_W-1:0];
         lst = (k == beats - 1);
         by  = lst ? 7'(tail) : 7'd64;
         exp_q.push_back({lst, by, bd});
      end
      @(posedge clk); #1;
      page_len = PAGE_LEN_W'(len);
      page_finish = 1'b1;
      dif.dout_ready = ready_for(mode, 0);
      for (int c = 0; c < 4000 && !done; c++) begin
         @(negedge clk);
         if (rd_en) begin
            check("rd_addr", rd_addr, next_addr);
            next_addr++; n_rd++;
            if (c < 50) stall_rd++;
         end
         obs = {dif.dout_last, dif.dout_bytes, dif.dout_data};
         if (dif.dout_valid) begin
            if (first_valid < 0) first_valid = c;
            if (stalled) check("stall_hold", obs, held);
            if (dif.dout_ready) begin
               stalled = 0;
               last_acc = c;
               if (exp_q.size() == 0) check("extra_beat", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("beat_data", obs[BEAT_W-1:0], e[BEAT_W-1:0]);
                  check("beat_last", obs[W-1], e[W-1]);
                  check("beat_bytes", obs[W-2:BEAT_W], e[W-2:BEAT_W]);
               end
            end else begin
               stalled = 1;
               held = obs;
            end
         end else if (stalled) begin
            check("valid_withdrawn", 0, 1);
            stalled = 0;
         end
         if (c == 1) check("busy_start", busy, 1);
         if (cl_finish) cl_cnt++;
         if (cl_finish && cl_cyc < 0) begin
            cl_cyc = c;
            check("busy_at_cl", busy, 1);
         end else if (cl_cyc >= 0 && c == cl_cyc + 1) begin
            check("busy_after_cl", busy, 0);
            done = 1;
         end
         if (!done) begin
            @(posedge clk); #1;
            dif.dout_ready = ready_for(mode, c + 1);
            if (cl_cyc >= 0) page_finish = hold;
            else if (mode == 2) page_finish = 1'($urandom_range(0, 1));
         end
      end
      check("timeout", done, 1);
      check("rd_count", n_rd, lines);
      check("beats_left", exp_q.size(), 0);
      check("cl_count", cl_cnt, 1);
      if (len == 0) begin
         check("cl_cycle", cl_cyc, 2);
         check("no_valid", first_valid == -1, 1);
      end else begin
         check("first_beat_cycle", first_valid, RD_LAT + 2);
         check("cl_cycle", cl_cyc, last_acc + 2);
      end
      if (mode == 0 && len > 0) check("throughput", last_acc - first_valid, beats - 1);
      if (mode == 3) check("stall_reads", stall_rd, FIFO_DEPTH);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < (1 << BANK_AW); i++) mem[i] = rand_line();
      for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
      dif.dout_ready = 1'b1;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_page(300, 0, 0);
      run_page(128, 1, 0);
      run_page(0, 0, 0);
      run_page(4096, 3, 0);

      // Level held high after completion: nothing may restart.
      run_page(500, 0, 1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("hold_no_redrain", {rd_en, dif.dout_valid, busy, cl_finish}, 0);
      end
      @(posedge clk); #1 page_finish = 1'b0;
      repeat (2) @(posedge clk);
      run_page(64, 0, 0);

      // Reset in the middle of FLUSH.
      repeat (2) @(posedge clk);
      #1 page_len = PAGE_LEN_W'(1024);
      page_finish = 1'b1;
      dif.dout_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk); #1;
         if (state === ST_FLUSH) found = 1;
      end
      check("reach_flush", found, 1);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("mid_reset");
      page_finish = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mid_reset_no_cl", cl_finish, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run_page(384, 0, 0);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(1, 4)) @(posedge clk);
         run_page($urandom_range(1, 3000), (i % 2 == 0) ? 2 : 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
